// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB slave-side bus bundle for the simulink2ppc snapshot register.
// Bit 0 is the MSB on every OPB vector, following OPB numbering.
interface opb_register_simulink2ppc_snap_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  // Handshake: a transfer is one select assertion; the slave answers with
  // exactly one Sl_xferAck pulse and drives Sl_DBus only in that cycle.
  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB readback register: user logic posts words, the CPU reads DATA/STATUS.
// Optional macro SNAP_TIMESTAMP_EN adds a cycle-count TSTAMP at offset 0x08.
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h0110_8100,
  parameter logic [31:0] C_HIGHADDR   = 32'h0110_81FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  opb_register_simulink2ppc_snap_if.slave opb,
  input  logic [31:0]                user_data_in,
  input  logic                       user_data_valid,
  output logic [1:0]                 state_dbg
);

  localparam logic [31:0] ADDR_MASK = C_HIGHADDR - C_BASEADDR;
  localparam bit unused_family = (C_FAMILY == "");

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                    state, state_nxt;
  logic [C_OPB_AWIDTH-1:0]   addr_val;
  logic [31:0]               offset;
  logic                      hit, accept, consume, status_clr, overrun;
  logic [C_OPB_DWIDTH-1:0]   rd_mux, rd_buf;
  logic [31:0]               data_q;
  logic                      new_q;
  logic [15:0]               ovr_cnt, ovr_base, ovr_nxt;
  logic                      unused_ok;

  assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_DBus, unused_family};

  assign addr_val   = opb.OPB_ABus;
  assign offset     = addr_val & ADDR_MASK;
  assign hit        = opb.OPB_select && ((addr_val & ~ADDR_MASK) == C_BASEADDR);
  assign accept     = (state == S_IDLE) && hit;
  assign consume    = accept && opb.OPB_RNW && (offset == 32'h0);
  assign status_clr = accept && !opb.OPB_RNW && (offset == 32'h4) && (|opb.OPB_BE);
  // A capture that lands on a consuming read replaces the word without loss.
  assign overrun    = user_data_valid && new_q && !consume;

`ifdef SNAP_TIMESTAMP_EN
  logic [31:0] cycle_cnt, tstamp;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      cycle_cnt <= 32'h0;
      tstamp    <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (user_data_valid) tstamp <= cycle_cnt;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (offset)
      32'h0: rd_mux = data_q;
      32'h4: rd_mux = {ovr_cnt, 15'h0, new_q};
`ifdef SNAP_TIMESTAMP_EN
      32'h8: rd_mux = tstamp;
`endif
      default: rd_mux = '0;
    endcase
  end

  // Clear happens before the overrun increment, so a coincident pair leaves 1.
  always_comb begin
    ovr_base = status_clr ? 16'h0 : ovr_cnt;
    ovr_nxt  = ovr_base;
    if (overrun && (ovr_base != 16'hFFFF)) ovr_nxt = ovr_base + 16'h1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hit) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_WAIT;
      S_WAIT:  if (!opb.OPB_select) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state   <= S_IDLE;
      rd_buf  <= '0;
      data_q  <= 32'h0;
      new_q   <= 1'b0;
      ovr_cnt <= 16'h0;
    end else begin
      state   <= state_nxt;
      ovr_cnt <= ovr_nxt;
      // Writes latch zero so the ack cycle drives nothing onto the wired-OR bus.
      if (accept) rd_buf <= opb.OPB_RNW ? rd_mux : '0;
      if (user_data_valid) begin
        data_q <= user_data_in;
        new_q  <= 1'b1;
      end else if (consume) begin
        new_q  <= 1'b0;
      end
    end
  end

  assign opb.Sl_xferAck = (state == S_ACK);
  assign opb.Sl_DBus    = (state == S_ACK) ? rd_buf : '0;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign state_dbg      = state;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for opb_register_simulink2ppc_snap: directed steps plus random
// transfers checked against a rule-level model of DATA/NEW/OVR_CNT/TSTAMP.
module tb_opb_register_simulink2ppc_snap;
  localparam logic [31:0] BASE = 32'h0110_8100;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] user_data_in = 32'h0;
  logic        user_data_valid = 1'b0;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_data, m_ts, m_cycle;
  logic        m_new;
  int          m_ovr;

  opb_register_simulink2ppc_snap_if bus();

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .opb            (bus.slave),
    .user_data_in   (user_data_in),
    .user_data_valid(user_data_valid),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 32'h0; m_new = 1'b0; m_ovr = 0; m_ts = 32'h0; m_cycle = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] off);
    case (off)
      32'h0: return m_data;
      32'h4: return {m_ovr[15:0], 15'h0, m_new};
`ifdef SNAP_TIMESTAMP_EN
      32'h8: return m_ts;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge; apply the register rules to the inputs present at that edge.
  task automatic tick(input bit consume, input bit clr);
    @(posedge clk);
    if (clr) m_ovr = 0;
    if (user_data_valid) begin
      if (m_new && !consume && m_ovr < 65535) m_ovr = m_ovr + 1;
      m_ts   = m_cycle;
      m_data = user_data_in;
      m_new  = 1'b1;
    end else if (consume) begin
      m_new = 1'b0;
    end
    m_cycle = m_cycle + 32'h1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.OPB_select = 1'b0; user_data_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic capture(input logic [31:0] d);
    @(negedge clk);
    user_data_valid = 1'b1; user_data_in = d;
    tick(1'b0, 1'b0);
    @(negedge clk);
    user_data_valid = 1'b0;
  endtask

  task automatic idle_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      user_data_valid = 1'($urandom_range(0, 1));
      user_data_in = $urandom;
      tick(1'b0, 1'b0);
    end
    @(negedge clk);
    user_data_valid = 1'b0;
  endtask

  // One complete OPB transfer with an optional capture in the hit cycle.
  task automatic xfer(input string tag, input logic [31:0] addr, input bit rnw,
                      input logic [3:0] be, input bit cap, input logic [31:0] cap_data,
                      output logic [31:0] rd_obs);
    logic        in_win;
    logic [31:0] off, exp;
    in_win = ((addr & ~MASK) == BASE);
    off    = addr & MASK;
    @(negedge clk);
    bus.OPB_ABus = addr; bus.OPB_RNW = rnw; bus.OPB_BE = be;
    bus.OPB_DBus = $urandom; bus.OPB_select = 1'b1;
    user_data_valid = cap; user_data_in = cap_data;
    #1 chk({tag, "_pre_ack"}, 32'(bus.Sl_xferAck), 32'h0);
    exp = (in_win && rnw) ? model_read(off) : 32'h0;
    tick(in_win && rnw && off == 32'h0, in_win && !rnw && off == 32'h4 && be != 4'h0);
    @(negedge clk);
    user_data_valid = 1'b0;
    chk({tag, "_ack"}, 32'(bus.Sl_xferAck), 32'(in_win));
    chk({tag, "_data"}, bus.Sl_DBus, exp);
    rd_obs = bus.Sl_DBus;
    bus.OPB_select = 1'b0;
    tick(1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_ack_once"}, 32'(bus.Sl_xferAck), 32'h0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    int acks;
    logic [31:0] offs [5];
    offs[0] = 32'h0; offs[1] = 32'h4; offs[2] = 32'h8; offs[3] = 32'h40; offs[4] = 32'hFC;
    bus.OPB_ABus = 32'h0; bus.OPB_BE = 4'h0; bus.OPB_DBus = 32'h0;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    model_reset();

    do_reset();
    chk("rst_state", 32'(state_dbg), 32'h0);
    chk("rst_ack", 32'(bus.Sl_xferAck), 32'h0);
    chk("rst_dbus", bus.Sl_DBus, 32'h0);
    chk("tied_outs", {29'h0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);

    xfer("rd_data_rst", BASE, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_data_rst", r, 32'h0);
    xfer("rd_stat_rst", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_stat_rst", r, 32'h0);

    capture(32'hDEADBEEF);
    xfer("rd_stat1", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_stat1", r, 32'h0000_0001);
    xfer("rd_data1", BASE, 1'b1, 4'hF, 1'b0, 32'h0, r);     chk("c_data1", r, 32'hDEADBEEF);
    xfer("rd_stat2", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_stat2", r, 32'h0);

    capture(32'd1); capture(32'd2); capture(32'd3);
    xfer("rd_stat3", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_stat3", r, 32'h0002_0001);
    xfer("rd_data3", BASE, 1'b1, 4'hF, 1'b0, 32'h0, r);     chk("c_data3", r, 32'd3);

    for (int i = 0; i < 32'h10000; i++) begin
      @(negedge clk);
      user_data_valid = 1'b1; user_data_in = $urandom;
      tick(1'b0, 1'b0);
    end
    @(negedge clk); user_data_valid = 1'b0;
    xfer("rd_sat", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r);   chk("c_sat", r, 32'hFFFF_0001);
    xfer("wr_stat", BASE + 4, 1'b0, 4'hF, 1'b0, 32'h0, r);  chk("c_wr_dbus", r, 32'h0);
    xfer("rd_clr", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r);   chk("c_clr", r, 32'h0000_0001);

    xfer("rd_drain", BASE, 1'b1, 4'hF, 1'b0, 32'h0, r);
    capture(32'h44);
    xfer("rd_race", BASE, 1'b1, 4'hF, 1'b1, 32'h55, r);     chk("c_race", r, 32'h44);
    xfer("rd_race_st", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_race_st", r, 32'h0000_0001);
    xfer("wr_clr_ovr", BASE + 4, 1'b0, 4'h1, 1'b1, 32'h66, r);
    xfer("rd_clr_ovr", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_clr_ovr", r, 32'h0001_0001);
    xfer("rd_ts", BASE + 8, 1'b1, 4'hF, 1'b0, 32'h0, r);

    // Select held for four cycles must produce a single ack.
    @(negedge clk);
    bus.OPB_ABus = BASE + 32'h40; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      @(negedge clk);
      acks += int'(bus.Sl_xferAck);
    end
    bus.OPB_select = 1'b0;
    tick(1'b0, 1'b0);
    chk("held_single_ack", 32'(acks), 32'd1);

    // Reset landing in the ACK cycle cancels the next ack.
    @(negedge clk);
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    tick(1'b1, 1'b0);
    @(negedge clk);
    chk("ack_before_rst", 32'(bus.Sl_xferAck), 32'h1);
    rst = 1'b1; bus.OPB_select = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("rst_ack_drop", 32'(bus.Sl_xferAck), 32'h0);
    chk("rst_fsm_idle", 32'(state_dbg), 32'h0);
    rst = 1'b0;
    xfer("rd_after_rst", BASE + 4, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_after_rst", r, 32'h0);

    xfer("rd_0x40", BASE + 32'h40, 1'b1, 4'hF, 1'b0, 32'h0, r); chk("c_0x40", r, 32'h0);
    xfer("out_win", BASE + 32'h100, 1'b1, 4'hF, 1'b0, 32'h0, r);
    xfer("out_win_lo", BASE - 32'h4, 1'b1, 4'hF, 1'b0, 32'h0, r);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      idle_random($urandom_range(0, 3));
      a = ($urandom_range(0, 15) == 0) ? 32'h0110_8300 : BASE + offs[$urandom_range(0, 4)];
      xfer("rand", a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
